// File: rtl/ex_stage.sv
// Purpose : execute stage; unpacks the ID/EX bundle, runs the ALU, resolves branch/jump,
//           registers results into EX/MEM and issues the PC redirect to fetch.
// Latency : 1 cycle (bundle sampled at edge t is visible on ex_* after edge t).
// Backpressure: stall holds every register and drops redirect_valid; flush overrides stall.
// Ports   : clock, reset (sync, active-low); ID_EX_out[137:0], in_valid, stall, flush in;
//           ex_valid, ex_alu_result, ex_store_data, ex_dest_reg, ex_RegWrite, ex_MemWrite,
//           ex_MemtoReg, ex_LS_bit, redirect_valid, redirect_pc out.
module ex_stage #(
  parameter int unsigned SQUASH_SLOTS = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [137:0] ID_EX_out,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         flush,
  output logic         ex_valid,
  output logic [31:0]  ex_alu_result,
  output logic [31:0]  ex_store_data,
  output logic [4:0]   ex_dest_reg,
  output logic         ex_RegWrite,
  output logic         ex_MemWrite,
  output logic         ex_MemtoReg,
  output logic [1:0]   ex_LS_bit,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc
);

  typedef struct packed {
    logic [1:0]  ls_bit;
    logic        reg_dst;
    logic [1:0]  branch;
    logic        mem_to_reg;
    logic [3:0]  alu_op;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        jump;
    logic        ext_op;
    logic        pc_to_reg;
    logic [31:0] pc_add_out;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [25:0] instr26;
  } id_ex_t;

  localparam logic [1:0] SLOTS = SQUASH_SLOTS[1:0];

  id_ex_t      bnd;
  logic [31:0] imm32;
  logic [31:0] opb;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic [4:0]  dest;
  logic        br_taken;
  logic        taken;
  logic [31:0] target;
  logic        accept;
  logic [1:0]  squash_cnt;

  assign bnd   = id_ex_t'(ID_EX_out);
  assign imm32 = bnd.ext_op ? {{16{bnd.instr26[15]}}, bnd.instr26[15:0]}
                            : {16'h0000, bnd.instr26[15:0]};
  assign opb   = bnd.alu_src ? imm32 : bnd.rt_val;
  assign shamt = bnd.instr26[10:6];

  always_comb begin
    alu_res = bnd.rs_val + opb;
    case (bnd.alu_op)
      4'd1:    alu_res = bnd.rs_val - opb;
      4'd2:    alu_res = bnd.rs_val & opb;
      4'd3:    alu_res = bnd.rs_val | opb;
      4'd4:    alu_res = bnd.rs_val ^ opb;
      4'd5:    alu_res = ~(bnd.rs_val | opb);
      4'd6:    alu_res = {31'd0, $signed(bnd.rs_val) < $signed(opb)};
      4'd7:    alu_res = {31'd0, bnd.rs_val < opb};
      4'd8:    alu_res = opb << shamt;
      4'd9:    alu_res = opb >> shamt;
      4'd10:   alu_res = $unsigned($signed(opb) >>> shamt);
      4'd11:   alu_res = {imm32[15:0], 16'h0000};
      default: alu_res = bnd.rs_val + opb;
    endcase
  end

  assign dest = bnd.pc_to_reg ? 5'd31 :
                bnd.reg_dst   ? bnd.instr26[15:11] : bnd.instr26[20:16];

  // Branch code 11 decodes as "no branch".
  assign br_taken = (bnd.branch == 2'b01 && bnd.rs_val == bnd.rt_val) ||
                    (bnd.branch == 2'b10 && bnd.rs_val != bnd.rt_val);
  assign taken    = bnd.jump || br_taken;
  // Jump wins when both are set.
  assign target   = bnd.jump ? {bnd.pc_add_out[31:28], bnd.instr26, 2'b00}
                             : bnd.pc_add_out + {{14{bnd.instr26[15]}}, bnd.instr26[15:0], 2'b00};

  // stall/flush are resolved by the priority chain below.
  assign accept = in_valid && (squash_cnt == 2'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_valid       <= 1'b0;
      ex_alu_result  <= '0;
      ex_store_data  <= '0;
      ex_dest_reg    <= '0;
      ex_RegWrite    <= 1'b0;
      ex_MemWrite    <= 1'b0;
      ex_MemtoReg    <= 1'b0;
      ex_LS_bit      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      squash_cnt     <= '0;
    end else if (flush) begin
      ex_valid       <= 1'b0;
      ex_RegWrite    <= 1'b0;
      ex_MemWrite    <= 1'b0;
      ex_MemtoReg    <= 1'b0;
      redirect_valid <= 1'b0;
      squash_cnt     <= '0;
    end else if (stall) begin
      // Hold everything, but never let a redirect pulse repeat.
      redirect_valid <= 1'b0;
    end else begin
      ex_valid       <= accept;
      ex_RegWrite    <= accept && bnd.reg_write;
      ex_MemWrite    <= accept && bnd.mem_write;
      ex_MemtoReg    <= accept && bnd.mem_to_reg;
      // Data lanes update unconditionally; they are meaningless while ex_valid=0.
      ex_alu_result  <= bnd.pc_to_reg ? bnd.pc_add_out : alu_res;
      ex_store_data  <= bnd.rt_val;
      ex_dest_reg    <= dest;
      ex_LS_bit      <= bnd.ls_bit;
      redirect_valid <= accept && taken;
      if (accept && taken) begin
        redirect_pc <= target;
        squash_cnt  <= SLOTS;
      end else if (in_valid && squash_cnt != 2'd0) begin
        // Wrong-path bundle: dropped, consumes one squash slot.
        squash_cnt <= squash_cnt - 2'd1;
      end
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute-stage consumer of the 138-bit ID/EX bundle. Unpacks the fields at the bit positions produced by the ID/EX register, then runs the ALU, resolves branches and jumps, and selects the destination register. It registers the results into the EX/MEM boundary and supports stall, flush and wrong-path squash. It sits between the ID/EX register and the memory stage, and drives the PC redirect back to fetch.

## Interface
Parameters:
- SQUASH_SLOTS, 2, number of accepted bundles discarded after a redirect (wrong-path slots in IF/ID and ID/EX); range 0–3.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- ID_EX_out  in  138  bundle, MSB first: LS_bit[137:136], RegDst[135], Branch[134:133], MemtoReg[132], ALUOp[131:128], MemWrite[127], ALUSrc[126], RegWrite[125], Jump[124], Ext_op[123], PctoReg[122], pc_add_out[121:90], rs_val[89:58], rt_val[57:26], instr26[25:0].
- in_valid  in  1  bundle holds a real instruction.
- stall  in  1  hold all state; do not accept the bundle.
- flush  in  1  discard the bundle and the pending results.
- ex_valid  out  1  EX/MEM result valid.
- ex_alu_result  out  32  ALU result, or pc_add_out when PctoReg=1.
- ex_store_data  out  32  rt_val passed to memory.
- ex_dest_reg  out  5  destination register number.
- ex_RegWrite, ex_MemWrite, ex_MemtoReg  out  1 each  forwarded controls; forced to 0 when ex_valid=0.
- ex_LS_bit  out  2  forwarded load/store width.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  redirect target.

## Operation
- imm32: instr26[15:0] sign-extended when Ext_op=1, zero-extended when Ext_op=0. shamt = instr26[10:6].
- Operand A is rs_val. Operand B is imm32 when ALUSrc=1, otherwise rt_val.
- ALUOp encoding:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor.
  - 6 slt (signed), 7 sltu; both return 0 or 1.
  - 8 sll B by shamt, 9 srl, 10 sra.
  - 11 lui, giving {imm[15:0],16'h0}.
  - 12–15 behave as add.
- Arithmetic is mod 2^32 and raises no overflow trap.
- Destination register:
  - PctoReg=1: 31.
  - Otherwise RegDst=1: instr26[15:11].
  - Otherwise: instr26[20:16].
- Branch codes:
  - 00 none.
  - 01 beq, taken when rs_val==rt_val.
  - 10 bne, taken when rs_val!=rt_val.
  - 11 is treated as none.
- Targets:
  - Branch: pc_add_out + (sext(instr26[15:0])<<2).
  - Jump: {pc_add_out[31:28], instr26, 2'b00}.
  - Jump takes priority over Branch.
- Accept condition: reset=1 && stall=0 && flush=0 && in_valid=1 && squash_cnt==0.
- Squash counter (2 bits):
  - A bundle with in_valid=1 while squash_cnt>0, stall=0 and flush=0 is dropped and decrements squash_cnt.
  - An accepted taken branch or jump loads squash_cnt=SQUASH_SLOTS and pulses redirect.
  - Bundles with in_valid=0 do not decrement the counter.

## Timing
- Reset (reset=0 at an edge): every output is 0, squash_cnt is 0, and redirect_pc is 0.
- Latency is 1 cycle. The bundle sampled at edge t appears on the ex_* outputs after edge t.
- redirect_valid is high for exactly the one cycle after the accepting edge. redirect_pc is valid in that cycle and holds its value afterwards.
- stall=1: all ex_* outputs, redirect state and squash_cnt hold. redirect_valid is forced to 0 after that edge, so a redirect is never repeated.
- flush=1, which overrides stall: ex_valid goes to 0, squash_cnt clears, and no redirect is generated.
- in_valid=0 with no stall: ex_valid goes to 0 and the data outputs may update but are don't-care.
- A dropped (squashed) bundle produces ex_valid=0 and never causes a redirect, even if it is a branch.
- reset=0 takes priority over everything, including mid-squash: the counter is lost.

## Test plan
- ALU sweep: rs=0xFFFFFFFF, rt=1, ALUSrc=0, ALUOp=0..11. Expect ex_alu_result:
  - 0, 0xFFFFFFFE, 1, 0xFFFFFFFF, 0xFFFFFFFE, 0.
  - slt=1, sltu=0.
  - sll/srl/sra by shamt=4 give 0x00000010, 0x00000000, 0x00000000 (shifting B=1).
- Immediates: imm=0x8000, ALUSrc=1, ALUOp=0, rs=0.
  - Ext_op=1 gives 0xFFFF8000; Ext_op=0 gives 0x00008000.
  - lui with imm=0x1234 gives 0x12340000.
- beq taken: pc_add_out=0x00000104, imm=0xFFFF, rs=rt=5.
  - Next cycle: redirect_valid=1, redirect_pc=0x00000100, ex_valid=1, ex_RegWrite=0.
  - The following two valid bundles give ex_valid=0.
  - The third bundle is accepted.
- jal: Jump=1, PctoReg=1, pc_add_out=0x40000008, instr26=0x0000010.
  - redirect_pc=0x40000040.
  - ex_dest_reg=31, ex_alu_result=0x40000008.
- Stall/flush:
  - stall for 3 cycles after a redirect: ex_* outputs and squash_cnt hold, redirect_valid pulses once only.
  - flush asserted together with stall: ex_valid=0 and squash_cnt=0 on the next edge.
- Reset mid-squash: reset=0 for 1 cycle with squash_cnt=2. After the edge all outputs are 0, and the next valid bundle is accepted.
